// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned CHK_W          = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR0  = 3'd1;
  localparam logic [2:0] ST_HDR1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_CHK   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERROR = 3'd7;

  // States in which a byte may be taken from the source.
  function automatic logic is_rx_state(input logic [STATE_W-1:0] s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

  function automatic logic is_busy_state(input logic [STATE_W-1:0] s);
    return is_rx_state(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes into a little-endian word; first byte lands in [7:0].
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_full_c
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;

  // Shifting right means the byte pushed on lane 3 ends up in [31:24].
  always_comb begin
    word_c      = {byte_in, word_q[WORD_W-1:BYTE_W]};
    word_full_c = push && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    lane_d      = lane_q;
    word_d      = word_q;
    if (clr) begin
      lane_d = '0;
      word_d = '0;
    end else if (push) begin
      lane_d = lane_q + LANE_W'(1);
      word_d = word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset
// until a checksum-verified image has been written from address 0.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_WE,
  output logic [ADDR_W-1:0] imem_A,
  output logic [WORD_W-1:0] imem_WD,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam logic [15:0] MAX_N  = 16'(MAX_WORDS);

  logic [STATE_W-1:0] state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic [CHK_W-1:0]   chk_q, chk_d;
  logic               rx_ready_q, rx_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_a_q, imem_a_d;
  logic [WORD_W-1:0]  imem_wd_q, imem_wd_d;
  logic               core_reset_q, core_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic              accept_c;
  logic [15:0]       n_full_c;
  logic              last_word_c;
  logic              pk_clr, pk_push;
  logic [WORD_W-1:0] pk_word_c;
  logic              pk_full_c;

  assign accept_c    = rx_valid && rx_ready_q;
  assign n_full_c    = {rx_data, n_q[7:0]};
  assign last_word_c = (16'(widx_q) == (n_q - 16'd1));

  byte_packer u_packer (
    .clk        (clk),
    .Reset      (Reset),
    .clr        (pk_clr),
    .push       (pk_push),
    .byte_in    (rx_data),
    .word_c     (pk_word_c),
    .word_full_c(pk_full_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    widx_d    = widx_q;
    chk_d     = chk_q;
    imem_a_d  = imem_a_q;
    imem_wd_d = imem_wd_q;
    pk_clr    = 1'b0;
    pk_push   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_HDR0;
          n_d     = '0;
          widx_d  = '0;
          chk_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      ST_HDR0: begin
        if (accept_c) begin
          n_d[7:0] = rx_data;
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept_c) begin
          n_d     = n_full_c;
          state_d = ((n_full_c == 16'd0) || (n_full_c > MAX_N)) ? ST_ERROR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          pk_push = 1'b1;
          chk_d   = chk_q + rx_data;
          if (pk_full_c) begin
            state_d   = ST_WRITE;
            imem_a_d  = {widx_q, 2'b00};
            imem_wd_d = pk_word_c;
          end
        end
      end
      ST_WRITE: begin
        // Index stops at N-1 so the address never wraps.
        if (last_word_c) begin
          state_d = ST_CHK;
        end else begin
          widx_d  = widx_q + WIDX_W'(1);
          state_d = ST_DATA;
        end
      end
      ST_CHK: begin
        if (accept_c) begin
          state_d = (rx_data == chk_q) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d   = is_rx_state(state_d);
    imem_we_d    = (state_d == ST_WRITE);
    busy_d       = is_busy_state(state_d);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
    core_reset_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      widx_q       <= '0;
      chk_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_a_q     <= '0;
      imem_wd_q    <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      chk_q        <= chk_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_a_q     <= imem_a_d;
      imem_wd_q    <= imem_wd_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_WE    = imem_we_q;
  assign imem_A     = imem_a_q;
  assign imem_WD    = imem_wd_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed frame table, randomized frames against a
// frame-level reference model, and hand sequences for reset and restart.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        Reset, start, rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        imem_WE, core_reset, busy, done, error;
  logic [9:0]  imem_A;
  logic [31:0] imem_WD;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] bq_t[$];

  logic [9:0]  wr_a[$];
  logic [31:0] wr_d[$];
  logic [9:0]  exp_a[$];
  logic [31:0] exp_d[$];

  typedef struct {
    logic [127:0] frame;
    int           len;
    int           gap;
    bit           exp_done;
    bit           exp_err;
    int           exp_nwr;
    logic [9:0]   first_a;
    logic [31:0]  first_wd;
    logic [9:0]   last_a;
    logic [31:0]  last_wd;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(10), .MAX_WORDS(256)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_WE   (imem_WE),
    .imem_A    (imem_A),
    .imem_WD   (imem_WD),
    .core_reset(core_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write log; the source must be stalled whenever a word is being written.
  always @(negedge clk) begin
    if (imem_WE === 1'b1) begin
      wr_a.push_back(imem_A);
      wr_d.push_back(imem_WD);
      check("ready_low_in_write", 32'(rx_ready), 32'd0);
      check("addr_aligned", 32'(imem_A[1:0]), 32'd0);
    end
  end

  // Frame-level reference: decode header, payload words, checksum verdict.
  task automatic model(input bq_t f, output bit exp_done, output bit exp_err);
    int n;
    int sum;
    exp_a.delete();
    exp_d.delete();
    n = int'(f[0]) + 256 * int'(f[1]);
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (n == 0 || n > 256) return;
    sum = 0;
    for (int w = 0; w < n; w++) begin
      exp_a.push_back(10'(w * 4));
      exp_d.push_back({f[5+4*w], f[4+4*w], f[3+4*w], f[2+4*w]});
      for (int k = 0; k < 4; k++) sum += int'(f[2+4*w+k]);
    end
    exp_done = (f[2+4*n] == 8'(sum));
    exp_err  = !exp_done;
  endtask

  function automatic bq_t build_frame(input int n, input bit good_chk);
    bq_t f;
    int s = 0;
    logic [7:0] b;
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    if (n == 0 || n > 256) return f;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      s += int'(b);
    end
    f.push_back(good_chk ? 8'(s) : 8'(s + 1 + int'($urandom_range(254, 0))));
    return f;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte and returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit start_noise);
    int gap;
    int waited;
    gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
    if (gap > 0) rx_valid = 1'b0;
    repeat (gap) begin
      if (start_noise && $urandom_range(2, 0) == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) begin
      check("rx_ready_timeout", 32'(waited), 32'd0);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic drive_frame(input bq_t f, input int gap_max, input bit start_noise, input bit do_start);
    int t;
    wr_a.delete();
    wr_d.delete();
    if (do_start) pulse_start();
    foreach (f[i]) send_byte(f[i], gap_max, start_noise);
    rx_valid = 1'b0;
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t >= 16) check("outcome_timeout", 32'(t), 32'd0);
  endtask

  task automatic compare_model(input string tag, input bit ed, input bit ee);
    check({tag, "_done"}, 32'(done), 32'(ed));
    check({tag, "_error"}, 32'(error), 32'(ee));
    check({tag, "_core_reset"}, 32'(core_reset), 32'(!ed));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_nwr"}, 32'(wr_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_a[i]), 32'(exp_a[i]));
      check({tag, "_data"}, wr_d[i], exp_d[i]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_WE), 32'd0);
    check({tag, "_a"}, 32'(imem_A), 32'd0);
    check({tag, "_wd"}, imem_WD, 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    bq_t f;
    bit  ed, ee;
    int  n, nwr;

    // Frame bytes are listed last-to-first so byte 0 sits in [7:0].
    vecs[0] = '{88'h97_00_A0_01_13_00_50_00_93_00_02, 11, 0, 1'b1, 1'b0, 2,
                10'h000, 32'h0050_0093, 10'h004, 32'h00A0_0113};
    vecs[1] = '{88'h60_00_A0_01_13_00_50_00_93_00_02, 11, 2, 1'b0, 1'b1, 2,
                10'h000, 32'h0050_0093, 10'h004, 32'h00A0_0113};
    vecs[2] = '{16'h00_00, 2, 1, 1'b0, 1'b1, 0, 10'h0, 32'h0, 10'h0, 32'h0};
    vecs[3] = '{16'h01_01, 2, 1, 1'b0, 1'b1, 0, 10'h0, 32'h0, 10'h0, 32'h0};
    vecs[4] = '{56'hAA_44_33_22_11_00_01, 7, 0, 1'b1, 1'b0, 1,
                10'h000, 32'h4433_2211, 10'h000, 32'h4433_2211};

    Reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    Reset = 1'b0;
    @(negedge clk);

    // Fixed frames.
    foreach (vecs[v]) begin
      f.delete();
      for (int i = 0; i < vecs[v].len; i++) f.push_back(vecs[v].frame[i*8 +: 8]);
      drive_frame(f, vecs[v].gap, 1'b0, 1'b1);
      check("vec_done", 32'(done), 32'(vecs[v].exp_done));
      check("vec_error", 32'(error), 32'(vecs[v].exp_err));
      check("vec_core_reset", 32'(core_reset), 32'(!vecs[v].exp_done));
      check("vec_nwr", 32'(wr_a.size()), 32'(vecs[v].exp_nwr));
      if (wr_a.size() > 0 && vecs[v].exp_nwr > 0) begin
        check("vec_first_a", 32'(wr_a[0]), 32'(vecs[v].first_a));
        check("vec_first_wd", wr_d[0], vecs[v].first_wd);
        check("vec_last_a", 32'(wr_a[wr_a.size()-1]), 32'(vecs[v].last_a));
        check("vec_last_wd", wr_d[wr_d.size()-1], vecs[v].last_wd);
      end
      repeat (2) @(negedge clk);
    end

    // Randomized frames against the reference model.
    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(5, 0) == 0) begin
        case ($urandom_range(2, 0))
          0:       n = 0;
          1:       n = 257 + int'($urandom_range(50, 0));
          default: n = 65535;
        endcase
      end else begin
        n = int'($urandom_range(8, 1));
      end
      f = build_frame(n, $urandom_range(3, 0) != 0);
      model(f, ed, ee);
      drive_frame(f, int'($urandom_range(3, 0)), $urandom_range(1, 0) == 1, 1'b1);
      compare_model("rand", ed, ee);
    end

    // Reset while the fourth word is being written aborts the load.
    f = build_frame(5, 1'b1);
    pulse_start();
    for (int i = 0; i < 18; i++) send_byte(f[i], 1, 1'b0);
    rx_valid = 1'b0;
    check("abort_we_before", 32'(imem_WE), 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check_reset_vals("abort");
    nwr = wr_a.size();
    repeat (3) @(negedge clk);
    check("abort_no_more_we", 32'(wr_a.size()), 32'(nwr));
    check("abort_idle_busy", 32'(busy), 32'd0);
    model(f, ed, ee);
    drive_frame(f, 1, 1'b0, 1'b1);
    compare_model("reload", ed, ee);

    // Full-size image with start noise, then restart from DONE.
    f = build_frame(256, 1'b1);
    model(f, ed, ee);
    drive_frame(f, 1, 1'b1, 1'b1);
    compare_model("max", ed, ee);
    if (wr_a.size() > 0) check("max_last_a", 32'(wr_a[wr_a.size()-1]), 32'h3FC);
    check("max_done", 32'(done), 32'd1);
    pulse_start();
    check("restart_core_reset", 32'(core_reset), 32'd1);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    f = build_frame(3, 1'b1);
    model(f, ed, ee);
    drive_frame(f, 2, 1'b1, 1'b0);
    compare_model("restart", ed, ee);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
